decode_stage: RTL and testbench

- Pipeline decode stage; sits directly downstream of the fetch stage and consumes its registered instruction_r and pc_plus_one_r.
- Contains the 8x16 register file, the two-word (immediate) instruction sequencer and load-use hazard detection.
- Drives stall_fetch back to fetch and loads the ID/EX pipeline register feeding execute.

---
 rtl/decode_stage.sv | 166 ++++++++++++++++
 tb/tb_decode_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage
//   Pipeline decode stage between fetch and execute. It holds the 8-entry
//   register file, sequences two-word (immediate) instructions, detects
//   load-use hazards and loads the ID/EX pipeline register.
//
//   Optional feature (macro DECODE_WB_BYPASS_EN): when defined, a register
//   read that matches the write-back index in the same cycle returns
//   wb_data. When undefined, the read returns the stored value.
//
// Ports
//   clk, reset          clock; async active-low reset
//   instruction_r       fetch instruction register
//   pc_plus_one_r       fetch pc+1 register
//   flush               branch-taken squash from execute
//   wb_en/addr/data     register-file write port from write-back
//   stall_fetch         combinational hold request to fetch
//   ex_*                ID/EX pipeline register contents
module decode_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int PC_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           instruction_r,
  input  logic [PC_WIDTH-1:0]   pc_plus_one_r,
  input  logic                  flush,
  input  logic                  wb_en,
  input  logic [2:0]            wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  stall_fetch,
  output logic                  ex_valid,
  output logic [4:0]            ex_opcode,
  output logic [2:0]            ex_rdst,
  output logic [2:0]            ex_rsrc1,
  output logic [2:0]            ex_rsrc2,
  output logic [DATA_WIDTH-1:0] ex_rdata1,
  output logic [DATA_WIDTH-1:0] ex_rdata2,
  output logic [DATA_WIDTH-1:0] ex_immediate,
  output logic [PC_WIDTH-1:0]   ex_pc_plus_one,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write
);

  typedef enum logic {IDLE = 1'b0, GET_IMM = 1'b1} state_t;

  typedef struct packed {
    logic                  valid;
    logic [4:0]            opcode;
    logic [2:0]            rdst;
    logic [2:0]            rsrc1;
    logic [2:0]            rsrc2;
    logic [DATA_WIDTH-1:0] rdata1;
    logic [DATA_WIDTH-1:0] rdata2;
    logic [DATA_WIDTH-1:0] imm;
    logic [PC_WIDTH-1:0]   pc_plus_one;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
  } idex_t;

  state_t                state_q;
  logic [15:2]           held_q;   // first word of a two-word instruction
  idex_t                 idex_q, idex_d;
  logic [DATA_WIDTH-1:0] rf_q [8];

  // Word being decoded: the held first word while collecting the immediate
  logic [15:2] dec_w;
  logic [4:0]  dec_op;
  logic [2:0]  rs1, rs2;
  logic [DATA_WIDTH-1:0] rdata1_d, rdata2_d;

  assign dec_w  = (state_q == GET_IMM) ? held_q : instruction_r[15:2];
  assign dec_op = dec_w[15:11];
  assign rs1    = dec_w[7:5];
  assign rs2    = dec_w[4:2];

  always_comb begin
`ifdef DECODE_WB_BYPASS_EN
    rdata1_d = (wb_en && (wb_addr == rs1)) ? wb_data : rf_q[rs1];
    rdata2_d = (wb_en && (wb_addr == rs2)) ? wb_data : rf_q[rs2];
`else
    rdata1_d = rf_q[rs1];
    rdata2_d = rf_q[rs2];
`endif
  end

  always_comb begin
    idex_d             = '0;
    idex_d.valid       = 1'b1;
    idex_d.opcode      = dec_op;
    idex_d.rdst        = dec_w[10:8];
    idex_d.rsrc1       = rs1;
    idex_d.rsrc2       = rs2;
    idex_d.rdata1      = rdata1_d;
    idex_d.rdata2      = rdata2_d;
    // In GET_IMM the incoming word is the immediate, never an instruction
    idex_d.imm         = (state_q == GET_IMM) ? DATA_WIDTH'(instruction_r) : '0;
    idex_d.pc_plus_one = pc_plus_one_r;
    idex_d.reg_write   = ((dec_op[4:3] == 2'b00) && (dec_op != 5'd0)) ||
                         (dec_op[4:3] == 2'b01) || (dec_op == 5'b10000);
    idex_d.mem_read    = (dec_op == 5'b10000);
    idex_d.mem_write   = (dec_op == 5'b10001);
  end

  // Hazard looks at the incoming word; both source fields are compared
  // whether or not the opcode actually uses them.
  logic in_nop, in_two_word, hazard;
  assign in_nop      = (instruction_r == 16'h0000);
  assign in_two_word = (instruction_r[15:14] == 2'b01) || (instruction_r[15:13] == 3'b100);
  assign hazard      = idex_q.mem_read && !in_nop &&
                       ((idex_q.rdst == instruction_r[7:5]) ||
                        (idex_q.rdst == instruction_r[4:2]));
  assign stall_fetch = !flush && (state_q == IDLE) && hazard;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      held_q  <= '0;
      idex_q  <= '0;
    end else if (flush) begin
      state_q <= IDLE;
      idex_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hazard || in_nop) begin
            idex_q <= '0;
          end else if (in_two_word) begin
            held_q  <= instruction_r[15:2];
            idex_q  <= '0;
            state_q <= GET_IMM;
          end else begin
            idex_q <= idex_d;
          end
        end
        GET_IMM: begin
          idex_q  <= idex_d;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else if (wb_en) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  assign ex_valid       = idex_q.valid;
  assign ex_opcode      = idex_q.opcode;
  assign ex_rdst        = idex_q.rdst;
  assign ex_rsrc1       = idex_q.rsrc1;
  assign ex_rsrc2       = idex_q.rsrc2;
  assign ex_rdata1      = idex_q.rdata1;
  assign ex_rdata2      = idex_q.rdata2;
  assign ex_immediate   = idex_q.imm;
  assign ex_pc_plus_one = idex_q.pc_plus_one;
  assign ex_reg_write   = idex_q.reg_write;
  assign ex_mem_read    = idex_q.mem_read;
  assign ex_mem_write   = idex_q.mem_write;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage
//   Directed test-plan steps followed by randomized traffic, all compared
//   against a transaction-level model of the decode rules.
module tb_decode_stage;

  typedef struct packed {
    logic        valid;
    logic [4:0]  op;
    logic [2:0]  rdst, rs1, rs2;
    logic [15:0] rd1, rd2, imm;
    logic [31:0] pc;
    logic        rw, mr, mw;
  } ex_t;

  logic        clk = 1'b0, reset = 1'b0;
  logic [15:0] instruction_r = '0;
  logic [31:0] pc_plus_one_r = '0;
  logic        flush = 1'b0, wb_en = 1'b0;
  logic [2:0]  wb_addr = '0;
  logic [15:0] wb_data = '0;
  logic        stall_fetch, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [4:0]  ex_opcode;
  logic [2:0]  ex_rdst, ex_rsrc1, ex_rsrc2;
  logic [15:0] ex_rdata1, ex_rdata2, ex_immediate;
  logic [31:0] ex_pc_plus_one;

  always #5 clk = ~clk;

  decode_stage #(.DATA_WIDTH(16), .PC_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .instruction_r(instruction_r),
    .pc_plus_one_r(pc_plus_one_r), .flush(flush), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .stall_fetch(stall_fetch),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_rdst(ex_rdst),
    .ex_rsrc1(ex_rsrc1), .ex_rsrc2(ex_rsrc2), .ex_rdata1(ex_rdata1),
    .ex_rdata2(ex_rdata2), .ex_immediate(ex_immediate),
    .ex_pc_plus_one(ex_pc_plus_one), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write));

  ex_t obs;
  assign obs = {ex_valid, ex_opcode, ex_rdst, ex_rsrc1, ex_rsrc2, ex_rdata1,
                ex_rdata2, ex_immediate, ex_pc_plus_one, ex_reg_write,
                ex_mem_read, ex_mem_write};

  // Reference model state: register contents, pending first word, ID/EX
  logic [15:0] m_rf [8];
  bit          m_pend;
  logic [15:0] m_held;
  ex_t         m_ex;
  bit          m_stall;
  logic        obs_stall;

  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [127:0] o, input logic [127:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic bit is_two_word(input logic [4:0] op);
    return (op[4:3] == 2'b01) || (op[4:2] == 3'b100);
  endfunction

  function automatic logic [15:0] rd(input logic [2:0] idx, input logic we,
                                     input logic [2:0] wa, input logic [15:0] wd);
`ifdef DECODE_WB_BYPASS_EN
    if (we && wa == idx) return wd;
`endif
    return m_rf[idx];
  endfunction

  function automatic ex_t mk(input logic [15:0] iw, input logic [15:0] imm,
                             input logic [31:0] pc, input logic we,
                             input logic [2:0] wa, input logic [15:0] wd);
    ex_t e;
    e.valid = 1'b1;
    e.op    = iw[15:11];
    e.rdst  = iw[10:8];
    e.rs1   = iw[7:5];
    e.rs2   = iw[4:2];
    e.rd1   = rd(iw[7:5], we, wa, wd);
    e.rd2   = rd(iw[4:2], we, wa, wd);
    e.imm   = imm;
    e.pc    = pc;
    e.rw    = (e.op inside {[5'd1:5'd7]}) || (e.op[4:3] == 2'b01) || (e.op == 5'd16);
    e.mr    = (e.op == 5'd16);
    e.mw    = (e.op == 5'd17);
    return e;
  endfunction

  // One cycle: drive at negedge, check stall before the edge, ID/EX after.
  task automatic step(input logic [15:0] w, input logic [31:0] pc, input logic fl,
                      input logic we, input logic [2:0] wa, input logic [15:0] wd);
    bit hz;
    ex_t nx;
    instruction_r = w; pc_plus_one_r = pc; flush = fl;
    wb_en = we; wb_addr = wa; wb_data = wd;
    #1;
    hz = m_ex.mr && (w != 16'h0) && (m_ex.rdst == w[7:5] || m_ex.rdst == w[4:2]);
    m_stall = !fl && !m_pend && hz;
    obs_stall = stall_fetch;
    check("stall_fetch", obs_stall, m_stall);
    if (fl) begin
      nx = '0; m_pend = 0;
    end else if (m_pend) begin
      nx = mk(m_held, w, pc, we, wa, wd); m_pend = 0;
    end else if (hz || w == 16'h0) begin
      nx = '0;
    end else if (is_two_word(w[15:11])) begin
      nx = '0; m_pend = 1; m_held = w;
    end else begin
      nx = mk(w, 16'h0, pc, we, wa, wd);
    end
    if (we) m_rf[wa] = wd;
    m_ex = nx;
    @(posedge clk); #1;
    check("idex", obs, m_ex);
    @(negedge clk);
  endtask

  // Async reset asserted mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    reset = 1'b0;
    #2;
    check("rst_idex", obs, 128'h0);
    check("rst_stall", stall_fetch, 1'b0);
    m_pend = 0; m_ex = '0;
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [15:0] w;
    logic [31:0] pc;
    logic [15:0] exp_byp;

    // Power-on reset
    do_reset();

    // Reset in the middle of operation
    step(16'h0B45, 32'h10, 0, 0, 0, 0);
    check("pre_rst_valid", ex_valid, 1'b1);
    do_reset();
    step(16'h0B45, 32'h11, 0, 0, 0, 0);
    check("post_rst_op", ex_opcode, 5'b00001);

    // Single-word decode with register reads
    step(16'h0000, 32'h0, 0, 1, 3'd2, 16'h0011);
    step(16'h0000, 32'h0, 0, 1, 3'd3, 16'h0022);
    step(16'h114C, 32'h21, 0, 0, 0, 0);
    check("sw_valid", ex_valid, 1'b1);
    check("sw_rdata1", ex_rdata1, 16'h0011);
    check("sw_rdata2", ex_rdata2, 16'h0022);
    check("sw_regwr", ex_reg_write, 1'b1);
    check("sw_pc", ex_pc_plus_one, 32'h21);

    // Two-word instruction
    step(16'h44A0, 32'h23, 0, 0, 0, 0);
    check("tw1_stall", obs_stall, 1'b0);
    check("tw1_valid", ex_valid, 1'b0);
    step(16'hBEEF, 32'h24, 0, 0, 0, 0);
    check("tw2_stall", obs_stall, 1'b0);
    check("tw2_op", ex_opcode, 5'b01000);
    check("tw2_imm", ex_immediate, 16'hBEEF);
    check("tw2_pc", ex_pc_plus_one, 32'h24);

    // Load-use: LDD r2 (two words), then a reader of r2
    step(16'h8200, 32'h30, 0, 0, 0, 0);
    step(16'h0005, 32'h31, 0, 0, 0, 0);
    check("lu_ldd_mr", ex_mem_read, 1'b1);
    step(16'h1140, 32'h32, 0, 0, 0, 0);
    check("lu_stall1", obs_stall, 1'b1);
    check("lu_bubble", ex_valid, 1'b0);
    step(16'h1140, 32'h32, 0, 0, 0, 0);
    check("lu_stall2", obs_stall, 1'b0);
    check("lu_issue", ex_opcode, 5'b00010);

    // Flush during GET_IMM
    step(16'h44A0, 32'h40, 0, 0, 0, 0);
    step(16'h114C, 32'h41, 1, 0, 0, 0);
    check("fl_bubble", ex_valid, 1'b0);
    step(16'h114C, 32'h42, 0, 0, 0, 0);
    check("fl_fresh_op", ex_opcode, 5'b00010);
    check("fl_fresh_imm", ex_immediate, 16'h0);

    // Same-cycle write-back and read of R3
`ifdef DECODE_WB_BYPASS_EN
    exp_byp = 16'h1234;
`else
    exp_byp = 16'h0022;
`endif
    step(16'h114C, 32'h50, 0, 1, 3'd3, 16'h1234);
    check("bypass_rd2", ex_rdata2, exp_byp);

    // Reset while collecting an immediate
    step(16'h44A0, 32'h60, 0, 0, 0, 0);
    do_reset();
    step(16'h114C, 32'h61, 0, 0, 0, 0);
    check("rst_imm_op", ex_opcode, 5'b00010);
    check("rst_imm_rd2", ex_rdata2, 16'h0);

    // Randomized traffic; fetch holds its word while stalled
    pc = 32'h100;
    w  = 16'h0;
    for (int i = 0; i < 400; i++) begin
      if (!m_stall) begin
        case ($urandom_range(0, 9))
          0:       w = 16'h0000;
          1, 2:    w = {5'b10000, 11'($urandom)};
          default: w = 16'($urandom);
        endcase
        pc = pc + 1;
      end
      step(w, pc, ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0),
           3'($urandom), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
